// File: rtl/stall_ctrl.sv
// stall_ctrl: load-use hazard stall generation plus sequencer for an iterative restoring 32-bit divider.
// Define DIV_SIGNED_EN to honour div_signed (DIV); without it every divide is unsigned.
module stall_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int STALL_W    = 5
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic               id_rreg1,
    input  logic [4:0]         id_ra1,
    input  logic               id_rreg2,
    input  logic [4:0]         id_ra2,
    input  logic               exe_mreg,
    input  logic [4:0]         exe_wa,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [31:0]        div_dividend,
    input  logic [31:0]        div_divisor,
    output logic [31:0]        div_quot,
    output logic [31:0]        div_rem,
    output logic               div_done,
    output logic [STALL_W-1:0] stall
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [STALL_W-1:0] STALL_LUSE = STALL_W'(3);
    localparam logic [STALL_W-1:0] STALL_DIV  = STALL_W'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_acc;
    logic [31:0]      r_q;
    logic [31:0]      r_dvs;
    logic [31:0]      r_quot;
    logic [31:0]      r_rem;

    logic        w_luse;
    logic        w_accept;
    logic        w_dbz;
    logic        w_lastStep;
    logic [31:0] w_dvdMag;
    logic [31:0] w_dvsMag;
    logic [32:0] w_shAcc;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_stepAcc;
    logic [31:0] w_stepQ;
    logic [31:0] w_finalQuot;
    logic [31:0] w_finalRem;

    assign w_luse = exe_mreg && (exe_wa != 5'd0) &&
                    ((id_rreg1 && (id_ra1 == exe_wa)) || (id_rreg2 && (id_ra2 == exe_wa)));

    assign w_accept   = (r_state == S_IDLE) && div_start;
    assign w_dbz      = (div_divisor == 32'd0);
    assign w_lastStep = (r_state == S_BUSY) && (r_cnt == CNT_W'(DIV_CYCLES - 1));

    // One restoring step: shift the next dividend bit in, keep the difference only if it did not borrow.
    assign w_shAcc   = {r_acc, r_q[31]};
    assign w_diff    = w_shAcc - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[32];
    assign w_stepAcc = w_ge ? w_diff[31:0] : w_shAcc[31:0];
    assign w_stepQ   = {r_q[30:0], w_ge};

`ifdef DIV_SIGNED_EN
    logic r_negQ;
    logic r_negR;
    logic w_dvdNeg;
    logic w_dvsNeg;

    assign w_dvdNeg    = div_signed & div_dividend[31];
    assign w_dvsNeg    = div_signed & div_divisor[31];
    assign w_dvdMag    = w_dvdNeg ? -div_dividend : div_dividend;
    assign w_dvsMag    = w_dvsNeg ? -div_divisor : div_divisor;
    assign w_finalQuot = r_negQ ? -w_stepQ : w_stepQ;
    assign w_finalRem  = r_negR ? -w_stepAcc : w_stepAcc;

    // Result signs are fixed at acceptance; the magnitudes run through the unsigned core.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_negQ <= 1'b0;
            r_negR <= 1'b0;
        end else if (w_accept) begin
            r_negQ <= w_dvdNeg ^ w_dvsNeg;
            r_negR <= w_dvdNeg;
        end
    end
`else
    logic w_unusedSigned;

    assign w_unusedSigned = div_signed;
    assign w_dvdMag       = div_dividend;
    assign w_dvsMag       = div_divisor;
    assign w_finalQuot    = w_stepQ;
    assign w_finalRem     = w_stepAcc;
`endif

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Divide stall wins over load-use; DONE releases the pipeline so a pending hazard is seen in IDLE.
    always_comb begin
        w_nextState = r_state;
        stall       = '0;
        div_done    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_luse) begin
                    stall = STALL_LUSE;
                end
                if (div_start) begin
                    stall       = stall | STALL_DIV;
                    w_nextState = w_dbz ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                stall = STALL_DIV;
                if (w_lastStep) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                div_done    = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        if (!cpu_rst_n) begin
            stall = '0;
        end
    end

    // Visible results change only when a divide completes, so they hold across later idle cycles.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_q    <= '0;
            r_dvs  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_q   <= w_dvdMag;
            r_dvs <= w_dvsMag;
            if (w_dbz) begin
                r_quot <= '1;
                r_rem  <= div_dividend;
            end
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_stepAcc;
            r_q   <= w_stepQ;
            if (w_lastStep) begin
                r_quot <= w_finalQuot;
                r_rem  <= w_finalRem;
            end
        end
    end

    assign div_quot = r_quot;
    assign div_rem  = r_rem;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: randomized scoreboard bench for stall_ctrl against a cycle-level behavioural model.
module tb_stall_ctrl;

    localparam int DIV_CYCLES = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct packed {
        logic       rreg1;
        logic [4:0] ra1;
        logic       rreg2;
        logic [4:0] ra2;
        logic       mreg;
        logic [4:0] wa;
    } hz_t;

    typedef struct packed {
        logic [4:0] stall;
        logic       done;
    } cycExp_t;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } resExp_t;

    logic        cpu_clk_50M;
    logic        cpu_rst_n;
    logic        id_rreg1;
    logic [4:0]  id_ra1;
    logic        id_rreg2;
    logic [4:0]  id_ra2;
    logic        exe_mreg;
    logic [4:0]  exe_wa;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        div_done;
    logic [4:0]  stall;

    cycExp_t cycQ[$];
    resExp_t resQ[$];
    cycExp_t curExp;
    resExp_t curRes;
    int      total;
    int      bad;
    int      mdlBusyLeft;
    bit      mdlDone;

    hz_t         hzNone;
    hz_t         hzRs;
    hz_t         hzRand;
    logic [31:0] rndDvd;
    logic [31:0] rndDvs;
    bit          rndStart;

    stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .STALL_W(5)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .id_rreg1    (id_rreg1),
        .id_ra1      (id_ra1),
        .id_rreg2    (id_rreg2),
        .id_ra2      (id_ra2),
        .exe_mreg    (exe_mreg),
        .exe_wa      (exe_wa),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_dividend(div_dividend),
        .div_divisor (div_divisor),
        .div_quot    (div_quot),
        .div_rem     (div_rem),
        .div_done    (div_done),
        .stall       (stall)
    );

    initial cpu_clk_50M = 1'b0;
    always #5 cpu_clk_50M = ~cpu_clk_50M;

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Architectural result from plain 64-bit arithmetic; truncating division keeps the dividend's remainder sign.
    function automatic resExp_t refDivide(input bit sgn, input logic [31:0] dvd, input logic [31:0] dvs);
        resExp_t res;
        longint  a;
        longint  b;
        if (dvs == 32'd0) begin
            res.q = 32'hFFFF_FFFF;
            res.r = dvd;
            return res;
        end
        if (sgn && SIGNED_EN) begin
            a = longint'($signed(dvd));
            b = longint'($signed(dvs));
        end else begin
            a = longint'({32'd0, dvd});
            b = longint'({32'd0, dvs});
        end
        res.q = 32'(a / b);
        res.r = 32'(a % b);
        return res;
    endfunction

    // One clock of stimulus; the model predicts this cycle's stall/done and queues any divide result.
    task automatic applyStimulus(input bit start, input bit sgn, input logic [31:0] dvd,
                                 input logic [31:0] dvs, input hz_t h);
        cycExp_t e;
        bit      luse;
        div_start    = start;
        div_signed   = sgn;
        div_dividend = dvd;
        div_divisor  = dvs;
        id_rreg1     = h.rreg1;
        id_ra1       = h.ra1;
        id_rreg2     = h.rreg2;
        id_ra2       = h.ra2;
        exe_mreg     = h.mreg;
        exe_wa       = h.wa;
        luse = h.mreg && (h.wa != 5'd0) &&
               ((h.rreg1 && h.ra1 == h.wa) || (h.rreg2 && h.ra2 == h.wa));
        if (mdlDone) begin
            e.stall = 5'b00000;
            e.done  = 1'b1;
            mdlDone = 1'b0;
        end else if (mdlBusyLeft > 0) begin
            e.stall = 5'b00111;
            e.done  = 1'b0;
            mdlBusyLeft--;
            if (mdlBusyLeft == 0) mdlDone = 1'b1;
        end else begin
            e.stall = (luse ? 5'b00011 : 5'b00000) | (start ? 5'b00111 : 5'b00000);
            e.done  = 1'b0;
            if (start) begin
                resQ.push_back(refDivide(sgn, dvd, dvs));
                if (dvs == 32'd0) mdlDone = 1'b1;
                else mdlBusyLeft = DIV_CYCLES;
            end
        end
        cycQ.push_back(e);
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic applyReset();
        cycExp_t e;
        cpu_rst_n = 1'b0;
        div_start = 1'b0;
        exe_mreg  = 1'b0;
        mdlBusyLeft = 0;
        mdlDone     = 1'b0;
        resQ.delete();
        e.stall = 5'b00000;
        e.done  = 1'b0;
        cycQ.push_back(e);
        @(posedge cpu_clk_50M);
        #1;
        checkOutput("quotReset", div_quot, 32'd0);
        checkOutput("remReset", div_rem, 32'd0);
        cpu_rst_n = 1'b1;
    endtask

    task automatic runDivide(input bit sgn, input logic [31:0] dvd, input logic [31:0] dvs, input hz_t h);
        applyStimulus(1'b1, sgn, dvd, dvs, h);
        while (mdlBusyLeft > 0 || mdlDone) applyStimulus(1'b1, sgn, dvd, dvs, h);
    endtask

    // Monitor: pops the per-cycle expectation and, on a completion, the queued divide result.
    always @(negedge cpu_clk_50M) begin
        if (cycQ.size() != 0) begin
            curExp = cycQ.pop_front();
            checkOutput("stall", 32'(stall), 32'(curExp.stall));
            checkOutput("div_done", 32'(div_done), 32'(curExp.done));
            if (curExp.done) begin
                checkOutput("resAvail", 32'(resQ.size()), 32'd1);
                if (resQ.size() != 0) begin
                    curRes = resQ.pop_front();
                    checkOutput("div_quot", div_quot, curRes.q);
                    checkOutput("div_rem", div_rem, curRes.r);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        mdlBusyLeft = 0;
        mdlDone     = 1'b0;
        hzNone = '0;
        hzRs   = '{rreg1: 1'b1, ra1: 5'd5, rreg2: 1'b0, ra2: 5'd0, mreg: 1'b1, wa: 5'd5};
        cpu_rst_n    = 1'b0;
        id_rreg1     = 1'b0;
        id_ra1       = 5'd0;
        id_rreg2     = 1'b0;
        id_ra2       = 5'd0;
        exe_mreg     = 1'b0;
        exe_wa       = 5'd0;
        div_start    = 1'b0;
        div_signed   = 1'b0;
        div_dividend = 32'd0;
        div_divisor  = 32'd0;
        repeat (2) @(posedge cpu_clk_50M);
        #1;
        applyReset();

        // Load-use hazard on rs, then on rt, then suppressed by r0 and by a non-load.
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, hzRs);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, hzNone);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0,
                      '{rreg1: 1'b0, ra1: 5'd0, rreg2: 1'b1, ra2: 5'd9, mreg: 1'b1, wa: 5'd9});
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0,
                      '{rreg1: 1'b1, ra1: 5'd0, rreg2: 1'b0, ra2: 5'd0, mreg: 1'b1, wa: 5'd0});
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0,
                      '{rreg1: 1'b1, ra1: 5'd5, rreg2: 1'b0, ra2: 5'd0, mreg: 1'b0, wa: 5'd5});

        // Directed divides, each followed by an idle cycle.
        runDivide(1'b0, 32'd100, 32'd7, hzNone);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, hzNone);
        runDivide(1'b1, 32'hFFFF_FF9C, 32'd7, hzNone);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, hzNone);
        runDivide(1'b0, 32'h0000_1234, 32'd0, hzNone);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, hzNone);
        runDivide(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, hzNone);
        runDivide(1'b1, 32'd100, 32'hFFFF_FFF9, hzNone);
        runDivide(1'b0, 32'hFFFF_FFFF, 32'd1, hzNone);

        // Hazard held through a divide must reappear once the divider returns to idle.
        runDivide(1'b0, 32'd1000, 32'd33, hzRs);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, hzRs);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, hzNone);

        // Abort a divide on its tenth cycle, then confirm the next one completes normally.
        applyStimulus(1'b1, 1'b0, 32'd5000, 32'd3, hzNone);
        repeat (9) applyStimulus(1'b1, 1'b0, 32'd5000, 32'd3, hzNone);
        applyReset();
        runDivide(1'b0, 32'd5000, 32'd3, hzNone);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, hzNone);

        for (int i = 0; i < 500; i++) begin
            hzRand.rreg1 = 1'($urandom_range(0, 1));
            hzRand.ra1   = 5'($urandom_range(0, 3));
            hzRand.rreg2 = 1'($urandom_range(0, 1));
            hzRand.ra2   = 5'($urandom_range(0, 3));
            hzRand.mreg  = 1'($urandom_range(0, 1));
            hzRand.wa    = 5'($urandom_range(0, 3));
            rndStart     = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: rndDvs = 32'd0;
                1: rndDvs = 32'($urandom_range(1, 9));
                2: rndDvs = 32'hFFFF_FFFF;
                default: rndDvs = $urandom;
            endcase
            rndDvd = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 200));
            applyStimulus(rndStart, 1'($urandom_range(0, 1)), rndDvd, rndDvs, hzRand);
        end

        repeat (DIV_CYCLES + 4) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, hzNone);
        checkOutput("resDrain", 32'(resQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
